// File: rtl/control_cuenta_if.sv
// Command/status bundle between the push-button control stage and the up/down counter.
// The bench or board wrapper drives the master side; control_cuenta sits on the slave side.
interface control_cuenta_if;
  logic       BTN_START;
  logic       BTN_DIR;
  logic       BTN_CLR;
  logic       MODE;
  logic       TC_IN;
  logic       ENABLE;
  logic       UP_DOWN;
  logic       CNT_CLRn;
  logic       RUNNING;
  logic [1:0] STATE;

  modport master (
    output BTN_START, BTN_DIR, BTN_CLR, MODE, TC_IN,
    input  ENABLE, UP_DOWN, CNT_CLRn, RUNNING, STATE
  );

  modport slave (
    input  BTN_START, BTN_DIR, BTN_CLR, MODE, TC_IN,
    output ENABLE, UP_DOWN, CNT_CLRn, RUNNING, STATE
  );
endinterface

// File: rtl/control_cuenta.sv
// Push-button conditioning, start/pause/stop FSM and tick prescaler that drives the
// ENABLE / UP_DOWN / CNT_CLRn controls of the downstream up/down counter.
module control_cuenta #(
  parameter int F_CLK      = 50_000_000,
  parameter int F_TICK     = 1,
  parameter int DEB_CYCLES = 1_000_000
) (
  input  logic           CLK,
  input  logic           RSTn,
  control_cuenta_if.slave bus
);
  localparam int DIV   = F_CLK / F_TICK;
  localparam int PW    = $clog2(DIV);
  localparam int DW    = $clog2(DEB_CYCLES + 1);
  localparam int N_BTN = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    PAUSE = 2'b10,
    DONE  = 2'b11
  } state_t;

  logic [N_BTN-1:0] btn_raw;
  logic [N_BTN-1:0] press;

  assign btn_raw = {bus.BTN_CLR, bus.BTN_DIR, bus.BTN_START};

  // Per button: 2-FF synchronizer, stability counter, registered rising-edge strobe.
  generate
    for (genvar gi = 0; gi < N_BTN; gi++) begin : g_btn
      logic [1:0]    sync_q, sync_d;
      logic [DW-1:0] cnt_q, cnt_d;
      logic          deb_q, deb_d;
      logic          prev_q, prev_d;
      logic          press_q, press_d;

      always_comb begin
        sync_d  = {sync_q[0], btn_raw[gi]};
        cnt_d   = '0;
        deb_d   = deb_q;
        prev_d  = deb_q;
        press_d = deb_q & ~prev_q;
        if (sync_q[1] != deb_q) begin
          if (cnt_q == DW'(DEB_CYCLES - 1)) begin
            deb_d = ~deb_q;
          end else begin
            cnt_d = cnt_q + DW'(1);
          end
        end
      end

      always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
          sync_q  <= '0;
          cnt_q   <= '0;
          deb_q   <= 1'b0;
          prev_q  <= 1'b0;
          press_q <= 1'b0;
        end else begin
          sync_q  <= sync_d;
          cnt_q   <= cnt_d;
          deb_q   <= deb_d;
          prev_q  <= prev_d;
          press_q <= press_d;
        end
      end

      assign press[gi] = press_q;
    end
  endgenerate

  logic start_s, dir_s, clr_s;
  assign start_s = press[0];
  assign dir_s   = press[1];
  assign clr_s   = press[2];

  state_t        state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic          en_q, en_d;
  logic          ud_q, ud_d;
  logic          clrn_q, clrn_d;
  logic          running_q, running_d;
  logic          wrap;
  logic          stop_at_tc;

  assign wrap       = (presc_q == PW'(DIV - 1));
  assign stop_at_tc = bus.MODE & bus.TC_IN;

  always_comb begin
    state_d = state_q;
    presc_d = presc_q;
    en_d    = 1'b0;
    ud_d    = ud_q;
    clrn_d  = 1'b1;

    if (dir_s && (state_q == IDLE || state_q == PAUSE)) begin
      ud_d = ~ud_q;
    end

    if (clr_s) begin
      state_d = IDLE;
      presc_d = '0;
      clrn_d  = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          presc_d = '0;
          if (start_s) state_d = RUN;
        end
        RUN: begin
          if (start_s) begin
            state_d = PAUSE;
          end else if (wrap) begin
            presc_d = '0;
            // In single-run mode the wrap that sees TC is swallowed and ends the run.
            if (stop_at_tc) state_d = DONE;
            else            en_d    = 1'b1;
          end else begin
            presc_d = presc_q + PW'(1);
          end
        end
        PAUSE: begin
          if (start_s) state_d = RUN;
        end
        DONE: begin
          presc_d = '0;
          if (start_s) begin
            state_d = IDLE;
            clrn_d  = 1'b0;
          end
        end
        default: state_d = IDLE;
      endcase
    end

    running_d = (state_d == RUN);
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state_q   <= IDLE;
      presc_q   <= '0;
      en_q      <= 1'b0;
      ud_q      <= 1'b1;
      clrn_q    <= 1'b0;
      running_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      presc_q   <= presc_d;
      en_q      <= en_d;
      ud_q      <= ud_d;
      clrn_q    <= clrn_d;
      running_q <= running_d;
    end
  end

  assign bus.ENABLE   = en_q;
  assign bus.UP_DOWN  = ud_q;
  assign bus.CNT_CLRn = clrn_q;
  assign bus.RUNNING  = running_q;
  assign bus.STATE    = state_q;
endmodule

// File: tb/tb_control_cuenta.sv
// Scoreboard bench for control_cuenta: a per-cycle reference model pushes expected outputs,
// a negedge monitor pops and compares; directed scenarios followed by random button traffic.
module tb_control_cuenta;
  localparam int DIV = 8;
  localparam int DEB = 4;
  localparam logic [1:0] S_IDLE  = 2'b00;
  localparam logic [1:0] S_RUN   = 2'b01;
  localparam logic [1:0] S_PAUSE = 2'b10;
  localparam logic [1:0] S_DONE  = 2'b11;

  typedef struct packed {
    logic       en;
    logic       ud;
    logic       clrn;
    logic       run;
    logic [1:0] st;
  } exp_t;

  logic CLK = 1'b0;
  logic RSTn;
  control_cuenta_if bus ();

  control_cuenta #(.F_CLK(8), .F_TICK(1), .DEB_CYCLES(DEB)) dut (
    .CLK  (CLK),
    .RSTn (RSTn),
    .bus  (bus)
  );

  always #5 CLK = ~CLK;

  int   n_checks = 0;
  int   n_pass   = 0;
  exp_t sb_q[$];

  // Reference model: buttons are accepted after DEB consecutive disagreeing synchronized
  // samples; a press acts on the FSM two edges after acceptance. Phase counts run cycles.
  logic [1:0] m_st;
  int         m_phase;
  bit         m_en, m_up, m_clrn;
  bit         m_d1[3], m_d2[3], m_deb[3], stb[3], raw[3];
  int         m_run[3], m_fire[3];
  int         m_edge = 0;
  bit         s;
  exp_t       e;

  always @(posedge CLK) begin
    m_edge++;
    if (!RSTn) begin
      m_st = S_IDLE; m_phase = 0; m_en = 0; m_up = 1; m_clrn = 0;
      for (int b = 0; b < 3; b++) begin
        m_d1[b] = 0; m_d2[b] = 0; m_deb[b] = 0; m_run[b] = 0; m_fire[b] = -1;
      end
    end else begin
      raw[0] = bus.BTN_START; raw[1] = bus.BTN_DIR; raw[2] = bus.BTN_CLR;
      for (int b = 0; b < 3; b++) begin
        stb[b] = (m_fire[b] == m_edge);
        if (stb[b]) m_fire[b] = -1;
        s = m_d2[b]; m_d2[b] = m_d1[b]; m_d1[b] = raw[b];
        if (s != m_deb[b]) begin
          m_run[b]++;
          if (m_run[b] == DEB) begin
            m_deb[b] = s; m_run[b] = 0;
            if (s) m_fire[b] = m_edge + 2;
          end
        end else begin
          m_run[b] = 0;
        end
      end
      m_en = 0; m_clrn = 1;
      if (stb[1] && (m_st == S_IDLE || m_st == S_PAUSE)) m_up = !m_up;
      if (stb[2]) begin
        m_st = S_IDLE; m_phase = 0; m_clrn = 0;
      end else if (m_st == S_IDLE) begin
        m_phase = 0;
        if (stb[0]) m_st = S_RUN;
      end else if (m_st == S_RUN) begin
        if (stb[0]) m_st = S_PAUSE;
        else begin
          m_phase++;
          if (m_phase == DIV) begin
            m_phase = 0;
            if (bus.MODE && bus.TC_IN) m_st = S_DONE;
            else m_en = 1;
          end
        end
      end else if (m_st == S_PAUSE) begin
        if (stb[0]) m_st = S_RUN;
      end else begin
        m_phase = 0;
        if (stb[0]) begin m_st = S_IDLE; m_clrn = 0; end
      end
    end
    e.en = m_en; e.ud = m_up; e.clrn = m_clrn; e.run = (m_st == S_RUN); e.st = m_st;
    sb_q.push_back(e);
  end

  exp_t want, got;
  always @(negedge CLK) begin
    if (sb_q.size() > 0) begin
      want = sb_q.pop_front();
      got  = {bus.ENABLE, bus.UP_DOWN, bus.CNT_CLRn, bus.RUNNING, bus.STATE};
      n_checks++;
      if (got === want) n_pass++;
      else $display("FAIL sb t=%0t got en=%b ud=%b clrn=%b run=%b st=%b want en=%b ud=%b clrn=%b run=%b st=%b",
                    $time, got.en, got.ud, got.clrn, got.run, got.st,
                    want.en, want.ud, want.clrn, want.run, want.st);
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge CLK);
    #1;
  endtask

  task automatic chk(input string name, input logic [7:0] g, input logic [7:0] w);
    n_checks++;
    if (g === w) n_pass++;
    else $display("FAIL %s got %0h want %0h", name, g, w);
  endtask

  task automatic press(input int btn, input int hold);
    if (btn == 0) bus.BTN_START = 1; else if (btn == 1) bus.BTN_DIR = 1; else bus.BTN_CLR = 1;
    cyc(hold);
    bus.BTN_START = 0; bus.BTN_DIR = 0; bus.BTN_CLR = 0;
    cyc(8);
  endtask

  task automatic wait_en(input int lim);
    bit seen = 0;
    for (int k = 0; k < lim && !seen; k++) begin
      cyc(1);
      if (bus.ENABLE === 1'b1) seen = 1;
    end
    n_checks++;
    if (seen) n_pass++;
    else $display("FAIL wait_enable got none want pulse within %0d cycles", lim);
  endtask

  int rem[3];
  initial begin
    RSTn = 0;
    bus.BTN_START = 0; bus.BTN_DIR = 0; bus.BTN_CLR = 0; bus.MODE = 0; bus.TC_IN = 0;
    cyc(3);
    chk("rst_state", {6'd0, bus.STATE}, 8'd0);
    chk("rst_clrn", {7'd0, bus.CNT_CLRn}, 8'd0);
    chk("rst_updown", {7'd0, bus.UP_DOWN}, 8'd1);
    // First start press: state changes on the 8th edge, ENABLE on edges 16 and 24.
    RSTn = 1; bus.BTN_START = 1;
    cyc(1); chk("clrn_after_rst", {7'd0, bus.CNT_CLRn}, 8'd1);
    cyc(6); chk("state_edge7", {6'd0, bus.STATE}, 8'd0);
    cyc(1); chk("state_edge8", {6'd0, bus.STATE}, 8'd1);
    chk("running_edge8", {7'd0, bus.RUNNING}, 8'd1);
    cyc(2); bus.BTN_START = 0;
    cyc(5); chk("en_edge15", {7'd0, bus.ENABLE}, 8'd0);
    cyc(1); chk("en_edge16", {7'd0, bus.ENABLE}, 8'd1);
    cyc(7); chk("en_edge23", {7'd0, bus.ENABLE}, 8'd0);
    cyc(1); chk("en_edge24", {7'd0, bus.ENABLE}, 8'd1);
    // Direction: glitch, accepted toggle in IDLE, ignored toggle in RUN.
    press(2, 6);
    press(1, 3); chk("dir_glitch", {7'd0, bus.UP_DOWN}, 8'd1);
    press(1, 6); chk("dir_idle", {7'd0, bus.UP_DOWN}, 8'd0);
    press(0, 6);
    press(1, 6); chk("dir_run", {7'd0, bus.UP_DOWN}, 8'd0);
    // Pause and resume.
    press(0, 6); chk("paused", {6'd0, bus.STATE}, 8'd2);
    cyc(40);
    press(0, 5);
    wait_en(20);
    // Single-run stop at TC.
    bus.MODE = 1;
    wait_en(20); wait_en(20);
    bus.TC_IN = 1;
    cyc(12); chk("done_state", {6'd0, bus.STATE}, 8'd3);
    chk("done_running", {7'd0, bus.RUNNING}, 8'd0);
    bus.TC_IN = 0;
    press(0, 6); chk("done_to_idle", {6'd0, bus.STATE}, 8'd0);
    bus.MODE = 0;
    // Clear and start rising together in RUN.
    press(0, 6); cyc(3);
    bus.BTN_CLR = 1; bus.BTN_START = 1;
    cyc(6); bus.BTN_CLR = 0; bus.BTN_START = 0; cyc(8);
    chk("clr_beats_start", {6'd0, bus.STATE}, 8'd0);
    // Asynchronous reset in RUN.
    press(0, 6); cyc(5);
    RSTn = 0; #1;
    chk("async_en", {7'd0, bus.ENABLE}, 8'd0);
    chk("async_state", {6'd0, bus.STATE}, 8'd0);
    chk("async_updown", {7'd0, bus.UP_DOWN}, 8'd1);
    cyc(3); RSTn = 1;
    // Random button traffic against the model.
    for (int b = 0; b < 3; b++) rem[b] = 0;
    for (int i = 0; i < 3000; i++) begin
      for (int b = 0; b < 3; b++) begin
        if (rem[b] == 0) begin
          rem[b] = $urandom_range(1, 12);
          if (b == 0) bus.BTN_START = ($urandom_range(0, 3) == 0);
          else if (b == 1) bus.BTN_DIR = ($urandom_range(0, 3) == 0);
          else bus.BTN_CLR = ($urandom_range(0, 7) == 0);
        end
        rem[b]--;
      end
      if ($urandom_range(0, 199) == 0) bus.MODE = ~bus.MODE;
      bus.TC_IN = ($urandom_range(0, 2) == 0);
      cyc(1);
    end
    cyc(5);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1);
  end
endmodule

// File: doc/control_cuenta.md
Name: control_cuenta

Overview:
Upstream control stage for the parametrizable up/down counter (contador). It turns raw push-buttons into clean commands and runs a start/pause/stop state machine. A prescaler generates the single-cycle ENABLE ticks that advance the counter. It also drives UP_DOWN and a synchronous-style clear strobe, and uses the counter's TC to stop at the terminal value in single-run mode.

Parameters:
F_CLK, 50_000_000, system clock frequency in Hz
F_TICK, 1, counter advance rate in Hz; DIV = F_CLK/F_TICK, must be >= 2, integer
DEB_CYCLES, 1_000_000, consecutive stable cycles required to accept a button level change (>= 2)

Ports:
CLK  in  1  system clock, rising edge
RSTn  in  1  asynchronous reset, active-low
BTN_START  in  1  raw start/pause button, active-high, asynchronous to CLK
BTN_DIR  in  1  raw direction-toggle button, active-high, asynchronous
BTN_CLR  in  1  raw clear button, active-high, asynchronous
MODE  in  1  0 = continuous (counter wraps), 1 = single-run (stop at TC); quasi-static
TC_IN  in  1  terminal count from downstream counter
ENABLE  out  1  one-cycle advance pulse to counter
UP_DOWN  out  1  direction to counter: 1 = up, 0 = down
CNT_CLRn  out  1  counter clear strobe, active-low, one cycle
RUNNING  out  1  high while in RUN
STATE  out  2  FSM state: 00 IDLE, 01 RUN, 10 PAUSE, 11 DONE

Behaviour:
- Reset (RSTn=0, asynchronous):
  - Outputs: STATE=IDLE, ENABLE=0, UP_DOWN=1, RUNNING=0, CNT_CLRn=0.
  - Internal: prescaler=0, synchronizers/debounced levels/debounce counters=0.
  - CNT_CLRn goes to 1 on the first CLK edge after RSTn deasserts.
- Input conditioning, per button:
  - 2-FF synchronizer.
  - Debounce counter, width $clog2(DEB_CYCLES+1). It counts while synchronized value != debounced level and clears when they are equal. At DEB_CYCLES-1 the debounced level flips and the counter clears.
  - Rising-edge detect on the debounced level gives a one-cycle press strobe. A raw level held stable yields its strobe exactly DEB_CYCLES+3 cycles after the first sampling edge. Glitches shorter than DEB_CYCLES produce no strobe. Release produces no strobe.
- Prescaler, width $clog2(DIV):
  - Counts 0..DIV-1 and wraps, only in RUN.
  - Holds its value in PAUSE, so resume continues the partial period.
  - Cleared to 0 on IDLE->RUN, on any clear, and in IDLE and DONE.
- ENABLE:
  - Registered output, high for exactly one cycle on the edge after the prescaler equals DIV-1 in RUN.
  - First ENABLE comes DIV cycles after entering RUN from IDLE, then one every DIV cycles.
  - Suppressed when MODE=1 and TC_IN=1 at that wrap.
- FSM transitions (clr strobe has priority over start strobe in the same cycle):
  - Any state + clr: go to IDLE, CNT_CLRn=0 for one cycle (registered), prescaler=0. UP_DOWN is unchanged.
  - IDLE + start: go to RUN.
  - RUN + start: go to PAUSE.
  - RUN, prescaler wrap, MODE=1, TC_IN=1: go to DONE, no ENABLE issued. MODE=0 never enters DONE.
  - PAUSE + start: go to RUN.
  - DONE + start: go to IDLE with a CNT_CLRn pulse, same as clr.
- Direction:
  - dir strobe toggles UP_DOWN only in IDLE or PAUSE; it is ignored in RUN and DONE.
  - A toggle and a start in the same cycle are both applied; the new direction is used by the first ENABLE.
- RUNNING = (STATE==RUN), registered with STATE. STATE and RUNNING update on the edge following the strobe.
- Reset mid-RUN: all outputs return to reset values immediately, and no ENABLE is emitted.

Test Plan:
- Use F_CLK=8, F_TICK=1 (DIV=8), DEB_CYCLES=4 for all scenarios.
- Reset, then hold BTN_START=1 for 10 cycles -> exactly one start strobe 7 cycles after the first sample; STATE 00->01; first ENABLE 8 cycles later, then every 8 cycles; UP_DOWN=1; CNT_CLRn low only on the first post-reset cycle.
- BTN_DIR glitch 3 cycles high -> no UP_DOWN change. Then BTN_DIR held high in IDLE -> UP_DOWN 1->0. Then press BTN_DIR in RUN -> UP_DOWN stays 0.
- In RUN, press start after prescaler=5 -> PAUSE, no ENABLE while paused (40 cycles). Press start again -> next ENABLE 3 cycles after re-entering RUN.
- MODE=1, TC_IN driven 1 at the 3rd prescaler wrap -> ENABLEs at wraps 1 and 2 only; STATE=11, RUNNING=0. Press start -> STATE=00, one CNT_CLRn=0 cycle.
- BTN_CLR and BTN_START rising on the same cycle in RUN -> IDLE (not PAUSE), one CNT_CLRn pulse, prescaler=0. Also assert RSTn=0 mid-RUN -> ENABLE=0, STATE=00, UP_DOWN=1 asynchronously.
